// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage upstream of the decode unit.
//
// Holds the program counter and fetches one 32-bit word per instruction
// over a level req / pulsed ack memory handshake. The fetched word stays
// on instruction while Fetch_ready is high. The control unit retires the
// word by asserting cu_advance while decode reports IDU_ready. The next PC
// is either pc + pc_increment or an absolute redirect target.
//
// Ports:
//   soc_clk         in   1   system clock, rising edge
//   reset           in   1   synchronous, active-low reset
//   mem_req         out  1   fetch request, held until acked
//   mem_addr        out  32  fetch address (always equals pc)
//   mem_ack         in   1   memory response valid, one-cycle pulse
//   mem_rdata       in   32  instruction word, valid with mem_ack
//   instruction     out  32  registered instruction to decode
//   Fetch_ready     out  1   instruction valid, level
//   IDU_ready       in   1   decode outputs valid
//   pc_increment    in   32  two's complement PC offset from decode
//   cu_advance      in   1   control unit retired the current instruction
//   cu_redirect     in   1   taken branch/jump, qualifies cu_redirect_pc
//   cu_redirect_pc  in   32  absolute redirect target
//   pc              out  32  address of the current instruction
//   misaligned_fetch out 1   sticky: next PC not 4-byte aligned
//   fetch_timeout   out  1   sticky: memory did not respond in time

module ifu_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        soc_clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic        Fetch_ready,
  input  logic        IDU_ready,
  input  logic [31:0] pc_increment,
  input  logic        cu_advance,
  input  logic        cu_redirect,
  input  logic [31:0] cu_redirect_pc,
  output logic [31:0] pc,
  output logic        misaligned_fetch,
  output logic        fetch_timeout
);

  // Counter must be able to hold TIMEOUT_CYCLES itself.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [31:0]   pc_next;
  logic [31:0]   instr_next;
  logic [31:0]   target;
  logic [CW-1:0] tmo_cnt, tmo_cnt_next;
  logic          mis_next;
  logic          to_next;

  // Handshake outputs are pure decodes of the state, so mem_req drops and
  // Fetch_ready rises in the same cycle after an ack.
  assign mem_req     = (state == FETCH);
  assign Fetch_ready = (state == VALID);
  assign mem_addr    = pc;

  // Next-state and next-datapath logic. Everything holds by default; only
  // the active state's transition changes a value.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    instr_next   = instruction;
    tmo_cnt_next = tmo_cnt;
    mis_next     = misaligned_fetch;
    to_next      = fetch_timeout;
    // Plain 32-bit add; wraps modulo 2^32 by construction.
    target       = cu_redirect ? cu_redirect_pc : (pc + pc_increment);

    case (state)
      IDLE: begin
        if (RESET_PC[1:0] != 2'b00) begin
          mis_next   = 1'b1;
          state_next = HALT;
        end else begin
          state_next = FETCH;
        end
      end

      FETCH: begin
        // An ack in the final allowed cycle still counts as a response.
        if (mem_ack) begin
          instr_next   = mem_rdata;
          tmo_cnt_next = '0;
          state_next   = VALID;
        end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          tmo_cnt_next = tmo_cnt + CW'(1);
          to_next      = 1'b1;
          state_next   = HALT;
        end else begin
          tmo_cnt_next = tmo_cnt + CW'(1);
        end
      end

      VALID: begin
        // Advance without decode being ready is ignored. Passing through
        // FETCH guarantees decode sees Fetch_ready low for a cycle.
        if (cu_advance && IDU_ready) begin
          pc_next = target;
          if (target[1:0] != 2'b00) begin
            mis_next   = 1'b1;
            state_next = HALT;
          end else begin
            state_next = FETCH;
          end
        end
      end

      HALT: begin
        state_next = HALT;
      end

      default: begin
        state_next = HALT;
      end
    endcase
  end

  // State and datapath registers; reset overrides everything, including
  // an ack arriving in the same cycle.
  always_ff @(posedge soc_clk) begin
    if (!reset) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      instruction      <= 32'h0;
      tmo_cnt          <= '0;
      misaligned_fetch <= 1'b0;
      fetch_timeout    <= 1'b0;
    end else begin
      state            <= state_next;
      pc               <= pc_next;
      instruction      <= instr_next;
      tmo_cnt          <= tmo_cnt_next;
      misaligned_fetch <= mis_next;
      fetch_timeout    <= to_next;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: a table of per-cycle vectors covers reset,
// zero-wait and two-cycle fetches, sequential advance, redirect, PC wrap,
// negative increment, gated advance and misaligned redirect. Hand-written
// sequences cover fetch timeout and reset colliding with an ack.

module tb_ifu_fetch;

  logic        soc_clk;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instruction;
  logic        Fetch_ready;
  logic        IDU_ready;
  logic [31:0] pc_increment;
  logic        cu_advance;
  logic        cu_redirect;
  logic [31:0] cu_redirect_pc;
  logic [31:0] pc;
  logic        misaligned_fetch;
  logic        fetch_timeout;

  int checks;
  int failures;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        idu;
    logic        adv;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] inc;
    logic        req;
    logic        frdy;
    logic [31:0] pcv;
    logic [31:0] instr;
    logic        mis;
    logic        tmo;
  } vec_t;

  vec_t vecs[$];

  ifu_fetch #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .soc_clk         (soc_clk),
    .reset           (reset),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .instruction     (instruction),
    .Fetch_ready     (Fetch_ready),
    .IDU_ready       (IDU_ready),
    .pc_increment    (pc_increment),
    .cu_advance      (cu_advance),
    .cu_redirect     (cu_redirect),
    .cu_redirect_pc  (cu_redirect_pc),
    .pc              (pc),
    .misaligned_fetch(misaligned_fetch),
    .fetch_timeout   (fetch_timeout)
  );

  // 10 ns clock.
  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and settle 1 ns past the active edge.
  task automatic step();
    @(posedge soc_clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic ack, input logic [31:0] rdata,
                       input logic idu, input logic adv, input logic redir,
                       input logic [31:0] rpc, input logic [31:0] inc);
    reset          = rst;
    mem_ack        = ack;
    mem_rdata      = rdata;
    IDU_ready      = idu;
    cu_advance     = adv;
    cu_redirect    = redir;
    cu_redirect_pc = rpc;
    pc_increment   = inc;
  endtask

  // Drive one vector's inputs and clock them in.
  task automatic applyStimulus(input vec_t v);
    drive(v.rst, v.ack, v.rdata, v.idu, v.adv, v.redir, v.rpc, v.inc);
    step();
  endtask

  task automatic checkVec(input int i, input vec_t v);
    checkOutput($sformatf("v%0d.mem_req", i), {31'b0, mem_req}, {31'b0, v.req});
    checkOutput($sformatf("v%0d.Fetch_ready", i), {31'b0, Fetch_ready}, {31'b0, v.frdy});
    checkOutput($sformatf("v%0d.pc", i), pc, v.pcv);
    checkOutput($sformatf("v%0d.mem_addr", i), mem_addr, v.pcv);
    checkOutput($sformatf("v%0d.instruction", i), instruction, v.instr);
    checkOutput($sformatf("v%0d.misaligned", i), {31'b0, misaligned_fetch}, {31'b0, v.mis});
    checkOutput($sformatf("v%0d.timeout", i), {31'b0, fetch_timeout}, {31'b0, v.tmo});
  endtask

  task automatic addVec(input logic rst, input logic ack, input logic [31:0] rdata,
                        input logic idu, input logic adv, input logic redir,
                        input logic [31:0] rpc, input logic [31:0] inc,
                        input logic req, input logic frdy, input logic [31:0] pcv,
                        input logic [31:0] instr, input logic mis, input logic tmo);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.idu = idu; v.adv = adv;
    v.redir = redir; v.rpc = rpc; v.inc = inc; v.req = req; v.frdy = frdy;
    v.pcv = pcv; v.instr = instr; v.mis = mis; v.tmo = tmo;
    vecs.push_back(v);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Each row: inputs during the cycle, then outputs just after the edge.
    //      rst  ack  rdata          idu  adv  rdr  rpc            inc           req  frdy pc             instr          mis  tmo
    addVec(1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,32'h0,         32'h0,        1'b0,1'b0,32'h0,         32'h0,         1'b0,1'b0); // 0 reset
    addVec(1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,32'h0,         32'h0,        1'b0,1'b0,32'h0,         32'h0,         1'b0,1'b0); // 1 reset
    addVec(1'b1,1'b0,32'h0,         1'b0,1'b0,1'b0,32'h0,         32'h0,        1'b1,1'b0,32'h0,         32'h0,         1'b0,1'b0); // 2 IDLE->FETCH
    addVec(1'b1,1'b1,32'h00500093,  1'b0,1'b0,1'b0,32'h0,         32'h0,        1'b0,1'b1,32'h0,         32'h00500093,  1'b0,1'b0); // 3 zero-wait ack
    addVec(1'b1,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h0,         32'h4,        1'b1,1'b0,32'h4,         32'h00500093,  1'b0,1'b0); // 4 retire +4
    addVec(1'b1,1'b0,32'h0,         1'b0,1'b0,1'b0,32'h0,         32'h0,        1'b1,1'b0,32'h4,         32'h00500093,  1'b0,1'b0); // 5 wait
    addVec(1'b1,1'b1,32'h00400113,  1'b0,1'b0,1'b0,32'h0,         32'h0,        1'b0,1'b1,32'h4,         32'h00400113,  1'b0,1'b0); // 6 ack
    addVec(1'b1,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h0,         32'h4,        1'b1,1'b0,32'h8,         32'h00400113,  1'b0,1'b0); // 7 retire +4
    addVec(1'b1,1'b0,32'h0,         1'b0,1'b0,1'b0,32'h0,         32'h0,        1'b1,1'b0,32'h8,         32'h00400113,  1'b0,1'b0); // 8 wait
    addVec(1'b1,1'b1,32'h00208193,  1'b0,1'b0,1'b0,32'h0,         32'h0,        1'b0,1'b1,32'h8,         32'h00208193,  1'b0,1'b0); // 9 ack
    addVec(1'b1,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h0,         32'h4,        1'b1,1'b0,32'hC,         32'h00208193,  1'b0,1'b0); // 10 retire +4
    addVec(1'b1,1'b1,32'h12345678,  1'b0,1'b0,1'b0,32'h0,         32'h0,        1'b0,1'b1,32'hC,         32'h12345678,  1'b0,1'b0); // 11 ack
    addVec(1'b1,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h100,       32'h4,        1'b1,1'b0,32'h100,       32'h12345678,  1'b0,1'b0); // 12 redirect
    addVec(1'b1,1'b1,32'hAAAA5555,  1'b0,1'b0,1'b0,32'h0,         32'h0,        1'b0,1'b1,32'h100,       32'hAAAA5555,  1'b0,1'b0); // 13 ack
    addVec(1'b1,1'b0,32'h0,         1'b1,1'b1,1'b1,32'hFFFFFFFC,  32'h0,        1'b1,1'b0,32'hFFFFFFFC,  32'hAAAA5555,  1'b0,1'b0); // 14 redirect top
    addVec(1'b1,1'b1,32'h11111111,  1'b0,1'b0,1'b0,32'h0,         32'h0,        1'b0,1'b1,32'hFFFFFFFC,  32'h11111111,  1'b0,1'b0); // 15 ack
    addVec(1'b1,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h0,         32'h8,        1'b1,1'b0,32'h4,         32'h11111111,  1'b0,1'b0); // 16 wrap +8
    addVec(1'b1,1'b1,32'h22222222,  1'b0,1'b0,1'b0,32'h0,         32'h0,        1'b0,1'b1,32'h4,         32'h22222222,  1'b0,1'b0); // 17 ack
    addVec(1'b1,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h10,        32'h4,        1'b1,1'b0,32'h10,        32'h22222222,  1'b0,1'b0); // 18 redirect 0x10
    addVec(1'b1,1'b1,32'h33333333,  1'b0,1'b0,1'b0,32'h0,         32'h0,        1'b0,1'b1,32'h10,        32'h33333333,  1'b0,1'b0); // 19 ack
    addVec(1'b1,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h0,         32'hFFFFFFF8, 1'b1,1'b0,32'h8,         32'h33333333,  1'b0,1'b0); // 20 -8
    addVec(1'b1,1'b1,32'h44444444,  1'b0,1'b0,1'b0,32'h0,         32'h0,        1'b0,1'b1,32'h8,         32'h44444444,  1'b0,1'b0); // 21 ack
    for (int k = 0; k < 5; k++) begin
      addVec(1'b1,1'b0,32'h0,       1'b0,1'b1,1'b1,32'h200,       32'h4,        1'b0,1'b1,32'h8,         32'h44444444,  1'b0,1'b0); // 22-26 gated
    end
    addVec(1'b1,1'b1,32'hDEADBEEF,  1'b0,1'b0,1'b0,32'h0,         32'h0,        1'b0,1'b1,32'h8,         32'h44444444,  1'b0,1'b0); // 27 stray ack
    addVec(1'b1,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h102,       32'h4,        1'b0,1'b0,32'h102,       32'h44444444,  1'b1,1'b0); // 28 misaligned
    addVec(1'b1,1'b1,32'hBEEFBEEF,  1'b1,1'b1,1'b0,32'h0,         32'h4,        1'b0,1'b0,32'h102,       32'h44444444,  1'b1,1'b0); // 29 HALT holds

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkVec(i, vecs[i]);
    end

    // Timeout: memory never acks.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    checkOutput("tmo.reset_clears_mis", {31'b0, misaligned_fetch}, 32'h0);
    reset = 1'b1;
    step();
    checkOutput("tmo.first_req", {31'b0, mem_req}, 32'h1);
    for (int k = 2; k <= 16; k++) begin
      step();
      checkOutput($sformatf("tmo.req_cycle%0d", k), {31'b0, mem_req}, 32'h1);
      checkOutput($sformatf("tmo.flag_cycle%0d", k), {31'b0, fetch_timeout}, 32'h0);
    end
    step();
    checkOutput("tmo.flag", {31'b0, fetch_timeout}, 32'h1);
    checkOutput("tmo.req_dropped", {31'b0, mem_req}, 32'h0);
    checkOutput("tmo.no_mis", {31'b0, misaligned_fetch}, 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFEEDFACE;
    step();
    mem_ack   = 1'b0;
    checkOutput("tmo.late_ack_instr", instruction, 32'h0);
    checkOutput("tmo.late_ack_ready", {31'b0, Fetch_ready}, 32'h0);
    checkOutput("tmo.still_flag", {31'b0, fetch_timeout}, 32'h1);

    // Reset colliding with an ack mid-fetch.
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    step();
    checkOutput("rst_ack.in_fetch", {31'b0, mem_req}, 32'h1);
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack   = 1'b0;
    checkOutput("rst_ack.instr", instruction, 32'h0);
    checkOutput("rst_ack.ready", {31'b0, Fetch_ready}, 32'h0);
    checkOutput("rst_ack.pc", pc, 32'h0);
    checkOutput("rst_ack.req", {31'b0, mem_req}, 32'h0);
    checkOutput("rst_ack.tmo_cleared", {31'b0, fetch_timeout}, 32'h0);
    reset = 1'b1;
    step();
    step();
    checkOutput("rst_ack.refetch_req", {31'b0, mem_req}, 32'h1);
    checkOutput("rst_ack.refetch_addr", mem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
